// File: rtl/score_display_driver.sv
// Binary score to 4-digit active-low seven-segment packer.
// Sequential double-dabble conversion; display_queue only updates with a complete result.
module score_display_driver #(
    parameter int unsigned BIN_W         = 14,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             update,
    output logic [27:0]      display_queue,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        ENCODE
    } state_t;

    localparam logic [BIN_W-1:0] MAX_SCORE = BIN_W'(9999);
    localparam logic [3:0]       LAST_ITER = 4'(BIN_W - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [27:0]      disp_q, disp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [15:0]      bcd_adj;
    logic [27:0]      encoded;
    logic             blank3, blank2, blank1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction applied before each shift keeps every nibble within 0..9.
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // A digit blanks only if it and every digit above it are zero; units always show.
    always_comb begin
        blank3  = (BLANK_LEADING != 0) && (bcd_q[15:12] == 4'd0);
        blank2  = blank3 && (bcd_q[11:8] == 4'd0);
        blank1  = blank2 && (bcd_q[7:4] == 4'd0);
        encoded = {blank3 ? SEG_BLANK : seg7(bcd_q[15:12]),
                   blank2 ? SEG_BLANK : seg7(bcd_q[11:8]),
                   blank1 ? SEG_BLANK : seg7(bcd_q[7:4]),
                   seg7(bcd_q[3:0])};
        if (ovf_q) begin
            encoded = {4{SEG_DASH}};
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (update) begin
                    shift_d = value;
                    ovf_d   = (value > MAX_SCORE);
                    bcd_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = {bcd_adj[14:0], shift_q[BIN_W-1]};
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                count_d = count_q + 4'd1;
                if (count_q == LAST_ITER) begin
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                disp_d  = encoded;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign display_queue = disp_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
